// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED sequencer: register map, mode encodings,
// reset values and small helpers used by the RTL and the testbench.
package led_seq_ctrl_pkg;

  localparam int AVS_ADDR_W = 2;
  localparam int AVS_DATA_W = 32;

  // Word addresses on the lightweight-bridge slave
  localparam logic [AVS_ADDR_W-1:0] ADDR_CTRL    = 2'd0;
  localparam logic [AVS_ADDR_W-1:0] ADDR_PATTERN = 2'd1;
  localparam logic [AVS_ADDR_W-1:0] ADDR_DIV     = 2'd2;
  localparam logic [AVS_ADDR_W-1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // CTRL register layout: bit 2 = enable, bits 1:0 = mode
  typedef struct packed {
    logic  en;
    mode_t mode;
  } ctrl_t;

  localparam ctrl_t       CTRL_RST    = '{en: 1'b1, mode: MODE_COUNT};
  localparam logic [7:0]  PATTERN_RST = 8'h00;
  localparam logic [23:0] DIV_RST     = 24'h0F_FFFF;
  localparam logic [7:0]  LED_RST     = 8'h00;
  localparam logic [7:0]  LED_ALL_ON  = 8'hFF;
  localparam logic [7:0]  SCAN_FIRST  = 8'h01;
  localparam logic [7:0]  SCAN_LAST   = 8'h80;

  // Mode sequence used by the front-panel key: 0 -> 1 -> 2 -> 3 -> 0
  function automatic mode_t next_mode(input mode_t m);
    logic [1:0] v;
    v = m;
    v = v + 2'd1;
    return mode_t'(v);
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Avalon-MM slave bundle between the HPS lightweight bridge and the sequencer.
interface led_seq_ctrl_if;
  import led_seq_ctrl_pkg::*;

  logic [AVS_ADDR_W-1:0] avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [AVS_DATA_W-1:0] avs_writedata;
  logic [AVS_DATA_W-1:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/led_seq_ctrl_key_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability
// counter. Output is the accepted level, 1 = pressed (key_n is active-low).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic pressed_o
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             sample;

  assign sample    = ~sync2_q;
  assign pressed_o = lvl_q;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sample != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sample;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and debounce state; released key reads as key_n = 1
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// HPS-controlled LED sequencer: register file, prescaler, four display modes
// (count / static / scan / blink) and two debounced front-panel keys.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  led_seq_ctrl_if.slave        avs,
  input  logic [1:0]           key_n,
  output logic [7:0]           led
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [23:0] div_q, div_d;
  logic [23:0] presc_q, presc_d;
  logic [7:0]  val_q, val_d;
  dir_t        dir_q, dir_d;
  logic        phase_q, phase_d;
  logic [7:0]  led_q, led_d;
  logic [31:0] rdata_q, rdata_d;
  logic        key1_prev_q;
  logic [1:0]  key_lvl;

  logic        wr_ctrl, wr_pattern, wr_div;
  logic        key1_press, mode_chg, tick;
  logic [7:0]  disp;
  logic        unused_wdata;

  assign wr_ctrl    = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign wr_pattern = avs.avs_write && (avs.avs_address == ADDR_PATTERN);
  assign wr_div     = avs.avs_write && (avs.avs_address == ADDR_DIV);
  assign key1_press = key_lvl[1] && !key1_prev_q;

  assign unused_wdata     = ^avs.avs_writedata[31:24];
  assign avs.avs_readdata = rdata_q;
  assign led              = led_q;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .key_n_i  (key_n[i]),
      .pressed_o(key_lvl[i])
    );
  end

  // Register file next state; an HPS CTRL write overrides a same-cycle key step
  always_comb begin
    ctrl_d    = ctrl_q;
    pattern_d = pattern_q;
    div_d     = div_q;
    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(avs.avs_writedata[2:0]);
    end else if (key1_press) begin
      ctrl_d.mode = next_mode(ctrl_q.mode);
    end
    if (wr_pattern) pattern_d = avs.avs_writedata[7:0];
    if (wr_div)     div_d     = avs.avs_writedata[23:0];
  end

  // Prescaler and mode state: reload on mode entry, advance on tick, freeze when disabled
  always_comb begin
    mode_chg = (ctrl_d.mode != ctrl_q.mode);
    tick     = 1'b0;
    presc_d  = presc_q;
    val_d    = val_q;
    dir_d    = dir_q;
    phase_d  = phase_q;

    if (wr_div || mode_chg) begin
      presc_d = '0;
    end else if (ctrl_d.en) begin
      if (presc_q == div_q) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end

    if (mode_chg) begin
      case (ctrl_d.mode)
        MODE_COUNT: val_d = 8'h00;
        MODE_SCAN: begin
          val_d = SCAN_FIRST;
          dir_d = DIR_UP;
        end
        MODE_BLINK:  phase_d = 1'b1;
        default:     ;
      endcase
    end else if (tick) begin
      case (ctrl_q.mode)
        MODE_COUNT: val_d = val_q + 8'd1;
        MODE_SCAN: begin
          if (dir_q == DIR_UP) begin
            val_d = {val_q[6:0], 1'b0};
            if (val_d == SCAN_LAST) dir_d = DIR_DOWN;
          end else begin
            val_d = {1'b0, val_q[7:1]};
            if (val_d == SCAN_FIRST) dir_d = DIR_UP;
          end
        end
        MODE_BLINK:  phase_d = ~phase_q;
        default:     ;
      endcase
    end
  end

  // LED drive: disable blanks, KEY[0] forces all-on, otherwise show mode state
  always_comb begin
    case (ctrl_d.mode)
      MODE_COUNT:  disp = val_d;
      MODE_STATIC: disp = pattern_d;
      MODE_SCAN:   disp = val_d;
      MODE_BLINK:  disp = phase_d ? pattern_d : 8'h00;
      default:     disp = 8'h00;
    endcase
    if (!ctrl_d.en) begin
      led_d = 8'h00;
    end else if (key_lvl[0]) begin
      led_d = LED_ALL_ON;
    end else begin
      led_d = disp;
    end
  end

  // Read mux samples current register values, so a same-cycle write reads old data
  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        ADDR_CTRL:    rdata_d = {29'd0, ctrl_q};
        ADDR_PATTERN: rdata_d = {24'd0, pattern_q};
        ADDR_DIV:     rdata_d = {8'd0, div_q};
        ADDR_STATUS:  rdata_d = {22'd0, key_lvl, led_q};
        default:      rdata_d = 32'd0;
      endcase
    end
  end

  // State registers; reset takes priority over any same-cycle bus write
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= CTRL_RST;
      pattern_q   <= PATTERN_RST;
      div_q       <= DIV_RST;
      presc_q     <= '0;
      val_q       <= 8'h00;
      dir_q       <= DIR_UP;
      phase_q     <= 1'b1;
      led_q       <= LED_RST;
      rdata_q     <= '0;
      key1_prev_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      pattern_q   <= pattern_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      val_q       <= val_d;
      dir_q       <= dir_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      rdata_q     <= rdata_d;
      key1_prev_q <= key_lvl[1];
    end
  end

endmodule
